ram_arbiter_2to1: RTL

// - Shares one sync_ram_16x16 between two requesters (port A, port B), one command per cycle.
// - Round-robin grant with a valid/ready request handshake and a pipelined read-response return.
// - Drives the RAM's we/re/addr/din from registers and consumes its registered dout.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/sync_ram_16x16.sv | 24 ++
 rtl/ram_arbiter_2to1.sv | 102 ++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   ADDR_W / DATA_W : default RAM geometry (16 x 16)
//   PORT_A / PORT_B : requester ids carried down the response pipeline
//   cmd_t           : one granted command {we, addr, wdata, id}
package ram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              id;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request vector, bit 0 = port A, bit 1 = port B
//   gnt[1:0] : one-hot grant (or zero), combinational from req and pointer
// The pointer names the port that wins a tie. It moves to the other port
// only when a grant is issued, so an idle cycle keeps the current priority.
module rr_arb2 import ram_arb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (ptr == PORT_B) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= PORT_A;
    else if (gnt[0]) ptr <= PORT_B;
    else if (gnt[1]) ptr <= PORT_A;
  end

endmodule

// File: rtl/sync_ram_16x16.sv
// 16 x 16 single-port synchronous RAM with registered read data.
//   clk  : rising-edge clock
//   we   : write enable, mem[addr] <= din at the clock edge
//   re   : read enable, dout <= mem[addr] at the clock edge
//   addr : word address
//   din  : write data
//   dout : registered read data, holds between reads
module sync_ram_16x16 (
  input  logic        clk,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter_2to1.sv
// Shares one sync_ram_16x16 between requesters A and B, one command per cycle.
//   clk, rst                  : clock, synchronous active-high reset
//   a_valid/a_ready           : port A request handshake (ready is combinational)
//   a_we/a_addr/a_wdata       : port A request fields
//   a_rsp_valid/a_rsp_rdata   : port A read response (one-cycle pulse / data)
//   b_*                       : same for port B
//   ram_we/re/addr/din        : registered RAM command
//   ram_dout                  : registered RAM read data
// A read accepted in cycle N is on the RAM pins in N+1 and its data is on
// ram_dout in N+2, where the response is presented.
module ram_arbiter_2to1 #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import ram_arb_pkg::*;

  logic [1:0] req, gnt;
  logic       accept;
  cmd_t       cmd;

  // read pipeline: stage 1 aligns with ram_re, stage 2 with ram_dout
  logic s1_valid, s1_id, s2_valid, s2_id;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  assign req = {b_valid, a_valid} & {2{~rst}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign accept  = |gnt;

  always_comb begin
    cmd = '{we: a_we, addr: a_addr, wdata: a_wdata, id: PORT_A};
    if (gnt[1]) cmd = '{we: b_we, addr: b_addr, wdata: b_wdata, id: PORT_B};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= PORT_A;
      s2_valid  <= 1'b0;
      s2_id     <= PORT_A;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      ram_we   <= accept & cmd.we;
      ram_re   <= accept & ~cmd.we;
      if (accept) begin
        ram_addr <= cmd.addr;
        ram_din  <= cmd.wdata;
      end
      s1_valid <= accept & ~cmd.we;
      s1_id    <= cmd.id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (a_rsp_valid) a_rdata_q <= ram_dout;
      if (b_rsp_valid) b_rdata_q <= ram_dout;
    end
  end

  assign a_rsp_valid = ~rst & s2_valid & (s2_id == PORT_A);
  assign b_rsp_valid = ~rst & s2_valid & (s2_id == PORT_B);

  // During the pulse the data comes straight from the RAM register so it is
  // visible in the same cycle; afterwards the captured copy holds it.
  assign a_rsp_rdata = a_rsp_valid ? ram_dout : a_rdata_q;
  assign b_rsp_rdata = b_rsp_valid ? ram_dout : b_rdata_q;

endmodule
